// File: rtl/rv32v_types_pkg.sv
// Shared RV32V vector types: element offset, element width and the
// micro-op entry held by vuop_buffer (optional bypass: VUOP_BUFFER_BYPASS_EN).
package rv32v_types_pkg;

  typedef logic [4:0] offset_t;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } sew_t;

  typedef struct packed {
    offset_t    offset;
    logic [4:0] uop_vl;
    logic       done;
    sew_t       sew;
  } vuop_t;

endpackage

// File: rtl/vuop_buffer.sv
// Circular micro-op FIFO between the element counter and execute.
// Define VUOP_BUFFER_BYPASS_EN to forward into an empty buffer same-cycle.
module vuop_buffer
  import rv32v_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     in_valid,
  input  offset_t                  in_offset,
  input  logic [4:0]               in_uop_vl,
  input  logic                     in_done,
  input  sew_t                     in_sew,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output offset_t                  out_offset,
  output logic [4:0]               out_uop_vl,
  output logic                     out_done,
  output sew_t                     out_sew,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  vuop_t          mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  vuop_t in_uop;
  vuop_t head;
  logic  empty;
  logic  full;
  logic  byp;
  logic  push;
  logic  pop;

  assign in_uop.offset = in_offset;
  assign in_uop.uop_vl = in_uop_vl;
  assign in_uop.done   = in_done;
  assign in_uop.sew    = in_sew;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  always_comb begin
    byp = 1'b0;
`ifdef VUOP_BUFFER_BYPASS_EN
    byp = empty && in_valid && !flush;
`endif
    out_valid = !empty || byp;
    head      = byp ? in_uop : mem_q[rd_ptr_q];
    stall     = full && !(out_valid && out_ready);
    // A bypassed uop that is accepted never touches storage.
    pop  = out_valid && out_ready && !flush && !byp;
    push = in_valid && !stall && !flush && !(byp && out_ready);
  end

  assign out_offset = head.offset;
  assign out_uop_vl = head.uop_vl;
  assign out_done   = head.done;
  assign out_sew    = head.sew;
  assign count      = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; validity comes only from count.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= in_uop;
  end

endmodule

// File: tb/tb_vuop_buffer.sv
// Directed and random checks of vuop_buffer against a queue model.
// Bypass expectations follow VUOP_BUFFER_BYPASS_EN.
module tb_vuop_buffer;
  import rv32v_types_pkg::*;

  localparam int DEPTH = 4;
`ifdef VUOP_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       nRST;
  logic       in_valid;
  offset_t    in_offset;
  logic [4:0] in_uop_vl;
  logic       in_done;
  sew_t       in_sew;
  logic       flush;
  logic       out_ready;
  logic       out_valid;
  offset_t    out_offset;
  logic [4:0] out_uop_vl;
  logic       out_done;
  sew_t       out_sew;
  logic       stall;
  logic [$clog2(DEPTH):0] count;

  int n_assert = 0;
  int n_fail   = 0;
  vuop_t q[$];

  vuop_buffer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_offset(in_offset),
    .in_uop_vl(in_uop_vl), .in_done(in_done), .in_sew(in_sew),
    .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_offset(out_offset),
    .out_uop_vl(out_uop_vl), .out_done(out_done), .out_sew(out_sew),
    .stall(stall), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge, check, update model, return at next negedge.
  task automatic cyc(input string tag, input logic v, input logic [4:0] off,
                     input logic [4:0] vl, input logic dn, input sew_t sw,
                     input logic r, input logic f);
    vuop_t u, h;
    logic bp, ev, es;
    in_valid  = v;
    in_offset = off;
    in_uop_vl = vl;
    in_done   = dn;
    in_sew    = sw;
    out_ready = r;
    flush     = f;
    u = '{offset: off, uop_vl: vl, done: dn, sew: sw};
    bp = BYP && (q.size() == 0) && v && !f;
    ev = (q.size() != 0) || bp;
    es = (q.size() == DEPTH) && !(ev && r);
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".stall"}, 32'(stall), 32'(es));
    chk({tag, ".count"}, 32'(count), q.size());
    if (ev) begin
      h = bp ? u : q[0];
      chk({tag, ".offset"}, 32'(out_offset), 32'(h.offset));
      chk({tag, ".vl"}, 32'(out_uop_vl), 32'(h.uop_vl));
      chk({tag, ".done"}, 32'(out_done), 32'(h.done));
      chk({tag, ".sew"}, 32'(out_sew), 32'(h.sew));
    end
    if (f) q.delete();
    else begin
      if (ev && r && !bp) void'(q.pop_front());
      if (v && !es && !(bp && r)) q.push_back(u);
    end
    @(negedge CLK);
  endtask

  task automatic idle(input string tag, input logic r);
    cyc(tag, 1'b0, 5'd0, 5'd0, 1'b0, SEW8, r, 1'b0);
  endtask

  initial begin
    nRST = 1'b0;
    in_valid = 1'b0; in_offset = '0; in_uop_vl = '0;
    in_done = 1'b0; in_sew = SEW8; flush = 1'b0; out_ready = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    // Fill to full, then drain in order.
    for (int i = 0; i < 4; i++)
      cyc("fill", 1'b1, 5'(4*i), 5'd8, 1'b0, SEW32, 1'b0, 1'b0);
    idle("full", 1'b0);
    chk("full.count", 32'(count), 32'd4);
    chk("full.stall", 32'(stall), 32'd1);
    for (int i = 0; i < 4; i++) idle("drain", 1'b1);
    idle("empty", 1'b0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++)
      cyc("fill2", 1'b1, 5'(i + 1), 5'd2, 1'b0, SEW16, 1'b0, 1'b0);
    cyc("fullpp", 1'b1, 5'd20, 5'd3, 1'b1, SEW8, 1'b1, 1'b0);
    chk("fullpp.count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) idle("drain2", 1'b1);
    idle("empty2", 1'b0);

    // Flush with push and pop at count=2.
    cyc("fl.a", 1'b1, 5'd5, 5'd1, 1'b0, SEW8, 1'b0, 1'b0);
    cyc("fl.b", 1'b1, 5'd6, 5'd1, 1'b0, SEW8, 1'b0, 1'b0);
    cyc("fl.f", 1'b1, 5'd28, 5'd9, 1'b1, SEW32, 1'b1, 1'b1);
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.valid", 32'(out_valid), 32'd0);
    idle("postfl", 1'b1);

    // Wrap-around streaming at one per cycle.
    for (int i = 1; i <= 10; i++)
      cyc("wrap", 1'b1, 5'(i), 5'(i), (i % 3) == 0, SEW16, 1'b1, 1'b0);
    idle("wrapend", 1'b1);
    idle("wrapidle", 1'b0);

`ifdef VUOP_BUFFER_BYPASS_EN
    cyc("byp", 1'b1, 5'd16, 5'd4, 1'b1, SEW8, 1'b1, 1'b0);
    chk("byp.count", 32'(count), 32'd0);
`endif

    for (int i = 0; i < 400; i++)
      cyc("rnd", 1'($urandom_range(0, 99) < 60), 5'($urandom),
          5'($urandom), 1'($urandom), sew_t'($urandom_range(0, 2)),
          1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 4));
    idle("rndend", 1'b1);
    for (int i = 0; i < 6; i++) idle("rnddrain", 1'b1);

    // Asynchronous reset with three entries held.
    for (int i = 0; i < 3; i++)
      cyc("pre", 1'b1, 5'(i + 9), 5'd7, 1'b0, SEW8, 1'b0, 1'b0);
    chk("pre.count", 32'(count), 32'd3);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst.valid", 32'(out_valid), 32'd0);
    chk("arst.stall", 32'(stall), 32'd0);
    chk("arst.count", 32'(count), 32'd0);
    q.delete();
    @(negedge CLK);
    nRST = 1'b1;
    idle("postrst", 1'b1);
    cyc("postrst.push", 1'b1, 5'd3, 5'd5, 1'b1, SEW32, 1'b0, 1'b0);
    idle("postrst.pop", 1'b1);
    idle("postrst.end", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
